// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel between two pipeline stages.
// A beat transfers on a rising clock edge where valid and ready are both high;
// the master must hold valid and data stable until that edge.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and saturating stall/flush counters.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    pipe_stage_reg_if.slave    up,
    pipe_stage_reg_if.master   dn,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic              main_valid, main_valid_n;
    logic              skid_valid, skid_valid_n;
    logic [DATA_W-1:0] main_data, main_data_n;
    logic [DATA_W-1:0] skid_data, skid_data_n;
    logic              in_ready;
    logic              acc_in, acc_out;

    // Skid mode keeps in_ready a pure register output; single mode lets it follow out_ready.
    assign in_ready = (SKID != 0) ? ~skid_valid : (~main_valid | dn.ready);
    assign acc_in   = up.valid & in_ready;
    assign acc_out  = main_valid & dn.ready;

    assign up.ready = in_ready;
    assign dn.valid = main_valid;
    assign dn.data  = main_data;

    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        if (flush) begin
            main_valid_n = 1'b0;
            main_data_n  = '0;
            skid_valid_n = 1'b0;
            skid_data_n  = '0;
        end else if (SKID != 0) begin
            if (acc_out && skid_valid) begin
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                skid_valid_n = 1'b0;
                skid_data_n  = '0;
            end else if (acc_out || !main_valid) begin
                main_valid_n = acc_in;
                main_data_n  = acc_in ? up.data : '0;
            end else if (acc_in) begin
                skid_valid_n = 1'b1;
                skid_data_n  = up.data;
            end
        end else begin
            skid_valid_n = 1'b0;
            skid_data_n  = '0;
            if (acc_in) begin
                main_valid_n = 1'b1;
                main_data_n  = up.data;
            end else if (acc_out) begin
                main_valid_n = 1'b0;
                main_data_n  = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            // Counters stick at all-ones rather than wrapping.
            if (main_valid && !dn.ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid, single-register and narrow-counter instances
// checked against a per-instance expected-payload queue plus inline checks.
module tb_pipe_stage_reg;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush1 = 1'b0;
  logic flush0 = 1'b0;
  logic flush4 = 1'b0;
  logic [15:0] stall1, fcnt1, stall0, fcnt0;
  logic [3:0]  stall4, fcnt4;

  int checks = 0;
  int errors = 0;
  int pushes0 = 0;
  int pops0 = 0;

  logic [63:0] exp_q1[$];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q4[$];

  pipe_stage_reg_if #(.DATA_W(64)) if1_up ();
  pipe_stage_reg_if #(.DATA_W(64)) if1_dn ();
  pipe_stage_reg_if #(.DATA_W(64)) if0_up ();
  pipe_stage_reg_if #(.DATA_W(64)) if0_dn ();
  pipe_stage_reg_if #(.DATA_W(64)) if4_up ();
  pipe_stage_reg_if #(.DATA_W(64)) if4_dn ();

  pipe_stage_reg #(.DATA_W(64), .SKID(1), .CNT_W(16)) u1 (
    .clock(clock), .reset(reset), .flush(flush1), .up(if1_up), .dn(if1_dn),
    .stall_cnt(stall1), .flush_cnt(fcnt1));
  pipe_stage_reg #(.DATA_W(64), .SKID(0), .CNT_W(16)) u0 (
    .clock(clock), .reset(reset), .flush(flush0), .up(if0_up), .dn(if0_dn),
    .stall_cnt(stall0), .flush_cnt(fcnt0));
  pipe_stage_reg #(.DATA_W(64), .SKID(1), .CNT_W(4)) u4 (
    .clock(clock), .reset(reset), .flush(flush4), .up(if4_up), .dn(if4_dn),
    .stall_cnt(stall4), .flush_cnt(fcnt4));

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // scoreboards: push on acceptance, pop/compare on delivery, flush/reset drop
  always @(negedge clock) begin
    if (reset) exp_q1.delete();
    else begin
      if (if1_dn.valid && if1_dn.ready) begin
        checks++;
        if (exp_q1.size() == 0) begin
          errors++; $display("FAIL sb1_extra: got %h want nothing", if1_dn.data);
        end else if (if1_dn.data !== exp_q1[0]) begin
          errors++; $display("FAIL sb1_data: got %h want %h", if1_dn.data, exp_q1[0]);
        end
        if (exp_q1.size() != 0) void'(exp_q1.pop_front());
      end
      if (flush1) exp_q1.delete();
      else if (if1_up.valid && if1_up.ready) exp_q1.push_back(if1_up.data);
    end
  end

  always @(negedge clock) begin
    if (reset) exp_q0.delete();
    else begin
      if (if0_dn.valid && if0_dn.ready) begin
        checks++; pops0++;
        if (exp_q0.size() == 0) begin
          errors++; $display("FAIL sb0_extra: got %h want nothing", if0_dn.data);
        end else if (if0_dn.data !== exp_q0[0]) begin
          errors++; $display("FAIL sb0_data: got %h want %h", if0_dn.data, exp_q0[0]);
        end
        if (exp_q0.size() != 0) void'(exp_q0.pop_front());
      end
      if (flush0) exp_q0.delete();
      else if (if0_up.valid && if0_up.ready) begin
        exp_q0.push_back(if0_up.data); pushes0++;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) exp_q4.delete();
    else begin
      if (if4_dn.valid && if4_dn.ready) begin
        checks++;
        if (exp_q4.size() == 0) begin
          errors++; $display("FAIL sb4_extra: got %h want nothing", if4_dn.data);
        end else if (if4_dn.data !== exp_q4[0]) begin
          errors++; $display("FAIL sb4_data: got %h want %h", if4_dn.data, exp_q4[0]);
        end
        if (exp_q4.size() != 0) void'(exp_q4.pop_front());
      end
      if (flush4) exp_q4.delete();
      else if (if4_up.valid && if4_up.ready) exp_q4.push_back(if4_up.data);
    end
  end

  // driver tasks: inputs change and outputs are checked at posedge+1
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    checks++; if (if1_dn.valid !== 1'b0) begin errors++; $display("FAIL rst_valid1: got %b want 0", if1_dn.valid); end
    checks++; if (if1_dn.data !== 64'd0) begin errors++; $display("FAIL rst_data1: got %h want 0", if1_dn.data); end
    checks++; if (if1_up.ready !== 1'b1) begin errors++; $display("FAIL rst_ready1: got %b want 1", if1_up.ready); end
    checks++; if (if0_up.ready !== 1'b1) begin errors++; $display("FAIL rst_ready0: got %b want 1", if0_up.ready); end
    checks++; if (if4_dn.valid !== 1'b0) begin errors++; $display("FAIL rst_valid4: got %b want 0", if4_dn.valid); end
    checks++; if (stall1 !== 16'd0 || fcnt1 !== 16'd0) begin errors++; $display("FAIL rst_cnt1: got %0d/%0d want 0/0", stall1, fcnt1); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_pass_through();
    logic [63:0] a = 64'h0000_0004_2402_0005;
    logic [63:0] b = 64'h0000_0008_AC41_0000;
    if1_dn.ready = 1'b1; if1_up.valid = 1'b1; if1_up.data = a;
    cyc();
    checks++; if (if1_dn.valid !== 1'b1 || if1_dn.data !== a) begin errors++; $display("FAIL pass_first: got %b/%h want 1/%h", if1_dn.valid, if1_dn.data, a); end
    if1_up.data = b;
    cyc();
    checks++; if (if1_dn.valid !== 1'b1 || if1_dn.data !== b) begin errors++; $display("FAIL pass_second: got %b/%h want 1/%h", if1_dn.valid, if1_dn.data, b); end
    if1_up.valid = 1'b0; if1_up.data = '0;
    cyc();
    checks++; if (if1_dn.valid !== 1'b0 || if1_dn.data !== 64'd0) begin errors++; $display("FAIL pass_drain: got %b/%h want 0/0", if1_dn.valid, if1_dn.data); end
    checks++; if (stall1 !== 16'd0) begin errors++; $display("FAIL pass_stall: got %0d want 0", stall1); end
  endtask

  task automatic test_back_to_back_skid();
    if1_dn.ready = 1'b0; if1_up.valid = 1'b1; if1_up.data = 64'h11;
    cyc();
    checks++; if (if1_up.ready !== 1'b1 || if1_dn.data !== 64'h11) begin errors++; $display("FAIL skid_a: got rdy=%b data=%h want 1/11", if1_up.ready, if1_dn.data); end
    if1_up.data = 64'h22;
    cyc();
    checks++; if (if1_up.ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready: got %b want 0", if1_up.ready); end
    if1_up.data = 64'h33;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (if1_up.ready !== 1'b0 || if1_dn.data !== 64'h11) begin errors++; $display("FAIL skid_hold: got rdy=%b data=%h want 0/11", if1_up.ready, if1_dn.data); end
    end
    checks++; if (stall1 !== 16'd4) begin errors++; $display("FAIL skid_stall: got %0d want 4", stall1); end
    if1_dn.ready = 1'b1;
    cyc();
    checks++; if (if1_dn.data !== 64'h22 || if1_up.ready !== 1'b1) begin errors++; $display("FAIL skid_b: got data=%h rdy=%b want 22/1", if1_dn.data, if1_up.ready); end
    cyc();
    checks++; if (if1_dn.data !== 64'h33) begin errors++; $display("FAIL skid_c: got %h want 33", if1_dn.data); end
    if1_up.valid = 1'b0; if1_up.data = '0;
    cyc();
    checks++; if (if1_dn.valid !== 1'b0 || exp_q1.size() != 0) begin errors++; $display("FAIL skid_drain: got valid=%b q=%0d want 0/0", if1_dn.valid, exp_q1.size()); end
    checks++; if (stall1 !== 16'd4) begin errors++; $display("FAIL skid_stall_end: got %0d want 4", stall1); end
  endtask

  task automatic test_flush();
    if1_dn.ready = 1'b0; if1_up.valid = 1'b1; if1_up.data = 64'h44;
    cyc();
    if1_up.data = 64'h55;
    cyc();
    flush1 = 1'b1; if1_up.data = 64'h66;
    cyc();
    flush1 = 1'b0; if1_up.valid = 1'b0; if1_up.data = '0;
    checks++; if (if1_dn.valid !== 1'b0 || if1_dn.data !== 64'd0) begin errors++; $display("FAIL flush_out: got %b/%h want 0/0", if1_dn.valid, if1_dn.data); end
    checks++; if (if1_up.ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", if1_up.ready); end
    checks++; if (fcnt1 !== 16'd1) begin errors++; $display("FAIL flush_cnt1: got %0d want 1", fcnt1); end
    checks++; if (stall1 !== 16'd6) begin errors++; $display("FAIL flush_stall: got %0d want 6", stall1); end
    // empty stage: accepted payload in the flush cycle is dropped
    if1_dn.ready = 1'b1; flush1 = 1'b1; if1_up.valid = 1'b1; if1_up.data = 64'h77;
    cyc();
    flush1 = 1'b0; if1_up.valid = 1'b0;
    checks++; if (if1_dn.valid !== 1'b0 || fcnt1 !== 16'd2) begin errors++; $display("FAIL flush_drop: got valid=%b cnt=%0d want 0/2", if1_dn.valid, fcnt1); end
    flush1 = 1'b1; if1_up.valid = 1'b1; if1_up.data = 64'h88;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (if1_dn.valid !== 1'b0 || fcnt1 !== 16'(3 + k)) begin errors++; $display("FAIL flush_held: got valid=%b cnt=%0d want 0/%0d", if1_dn.valid, fcnt1, 3 + k); end
    end
    flush1 = 1'b0; if1_up.valid = 1'b0; if1_up.data = '0;
    cyc();
    checks++; if (if1_dn.valid !== 1'b0 || exp_q1.size() != 0) begin errors++; $display("FAIL flush_after: got valid=%b q=%0d want 0/0", if1_dn.valid, exp_q1.size()); end
  endtask

  task automatic test_no_skid();
    logic mv = 1'b0;
    logic exp_rdy;
    logic [63:0] nd = 64'd1;
    for (int i = 0; i < 12; i++) begin
      if0_dn.ready = (i % 3 != 1);
      if0_up.valid = 1'b1; if0_up.data = nd;
      #1;
      exp_rdy = !mv || if0_dn.ready;
      checks++; if (if0_up.ready !== exp_rdy) begin errors++; $display("FAIL ns_ready%0d: got %b want %b", i, if0_up.ready, exp_rdy); end
      checks++; if (if0_dn.valid !== mv) begin errors++; $display("FAIL ns_valid%0d: got %b want %b", i, if0_dn.valid, mv); end
      if (exp_rdy) begin mv = 1'b1; nd = nd + 64'd1; end
      else if (mv && if0_dn.ready) mv = 1'b0;
      cyc();
    end
    if0_up.valid = 1'b0; if0_up.data = '0; if0_dn.ready = 1'b1;
    cyc();
    checks++; if (if0_dn.valid !== 1'b0 || exp_q0.size() != 0) begin errors++; $display("FAIL ns_drain: got valid=%b q=%0d want 0/0", if0_dn.valid, exp_q0.size()); end
    checks++; if (pops0 != int'(nd) - 1 || pushes0 != int'(nd) - 1) begin errors++; $display("FAIL ns_count: got in=%0d out=%0d want %0d", pushes0, pops0, int'(nd) - 1); end
  endtask

  task automatic test_saturate();
    int want;
    if4_dn.ready = 1'b0; if4_up.valid = 1'b1; if4_up.data = 64'h99;
    cyc();
    if4_up.valid = 1'b0; if4_up.data = '0;
    checks++; if (if4_dn.valid !== 1'b1 || stall4 !== 4'd0) begin errors++; $display("FAIL sat_load: got valid=%b cnt=%0d want 1/0", if4_dn.valid, stall4); end
    for (int k = 2; k <= 21; k++) begin
      cyc();
      want = (k - 1 > 15) ? 15 : k - 1;
      checks++; if (stall4 !== 4'(want)) begin errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, stall4, want); end
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if (stall4 !== 4'd0 || if4_dn.valid !== 1'b0 || if4_dn.data !== 64'd0) begin errors++; $display("FAIL sat_reset: got cnt=%0d valid=%b data=%h want 0/0/0", stall4, if4_dn.valid, if4_dn.data); end
    cyc();
  endtask

  task automatic test_reset_flush();
    if1_dn.ready = 1'b0; if1_up.valid = 1'b1; if1_up.data = 64'hA1;
    cyc();
    if1_up.data = 64'hB2;
    cyc();
    checks++; if (if1_up.ready !== 1'b0) begin errors++; $display("FAIL rf_full: got %b want 0", if1_up.ready); end
    reset = 1'b1; flush1 = 1'b1; if1_up.data = 64'hC3;
    cyc();
    reset = 1'b0; flush1 = 1'b0; if1_up.valid = 1'b0; if1_up.data = '0;
    checks++; if (if1_dn.valid !== 1'b0 || if1_dn.data !== 64'd0 || if1_up.ready !== 1'b1) begin errors++; $display("FAIL rf_out: got %b/%h/%b want 0/0/1", if1_dn.valid, if1_dn.data, if1_up.ready); end
    checks++; if (fcnt1 !== 16'd0 || stall1 !== 16'd0) begin errors++; $display("FAIL rf_cnt: got flush=%0d stall=%0d want 0/0", fcnt1, stall1); end
    cyc();
    checks++; if (if1_dn.valid !== 1'b0 || fcnt1 !== 16'd0) begin errors++; $display("FAIL rf_after: got valid=%b flush=%0d want 0/0", if1_dn.valid, fcnt1); end
  endtask

  initial begin
    if1_up.valid = 1'b0; if1_up.data = '0; if1_dn.ready = 1'b0;
    if0_up.valid = 1'b0; if0_up.data = '0; if0_dn.ready = 1'b0;
    if4_up.valid = 1'b0; if4_up.data = '0; if4_dn.ready = 1'b0;
    test_reset();
    test_pass_through();
    test_back_to_back_skid();
    test_flush();
    test_no_skid();
    test_saturate();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register: the next generation of the IF/ID-style latch, generalised to any payload width.
- Replaces the bare write-enable/flush latch with a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, and saturating stall/flush performance counters.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, ...). A zero payload denotes a bubble (nop).

Parameters:
- DATA_W, 64, payload width in bits (e.g. {pc4, inst}).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of each performance counter.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream payload valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept a payload this cycle.
- out_valid  out  1  out_data holds a live payload.
- out_data  out  DATA_W  payload to downstream; all-zero whenever out_valid=0.
- out_ready  in  1  downstream accepts this cycle (low = stall, the successor of wpcir=0).
- flush  in  1  discard all held payloads (branch/exception squash).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- flush_cnt  out  CNT_W  cycles in which flush was sampled high.

Behaviour:
- Reset (sampled at the clock edge, highest priority):
  - main_valid=0, skid_valid=0, main_data=0, skid_data=0.
  - stall_cnt=0, flush_cnt=0.
  - Outputs: out_valid=0, out_data=0. in_ready=1 in both modes.
- Handshake definitions:
  - acc_in = in_valid & in_ready.
  - acc_out = out_valid & out_ready.
  - out_valid=main_valid; out_data=main_data.
- SKID=1:
  - in_ready = ~skid_valid, a pure register output with no combinational path from out_ready.
  - Same edge: main empty, or acc_out with skid empty -> accepted payload loads main.
  - Same edge: main full, no acc_out, acc_in -> accepted payload loads skid (skid_valid=1).
  - Same edge: acc_out with skid_valid=1 -> skid moves to main; skid cleared to 0; in_ready rises next cycle. No input is accepted that cycle.
  - acc_out with no refill -> main_valid=0, main_data=0.
- SKID=0:
  - in_ready = ~main_valid | out_ready (combinational).
  - acc_in loads main. acc_out with no acc_in empties main.
  - Skid registers are absent (tie off).
- Latency: 1 cycle from acc_in to out_valid when the stage is empty. Throughput is 1 payload per cycle while out_ready=1.
- Flush (priority below reset, above all data movement):
  - At the edge, main and skid valid bits and data are cleared to 0.
  - Any payload offered with acc_in in the same cycle is dropped; the upstream sees it as consumed.
  - A payload acknowledged by acc_out in the flush cycle counts as delivered.
  - Next cycle: out_valid=0, in_ready=1.
  - Flush held for N cycles keeps the stage empty for N cycles.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones; it does not wrap.
  - stall_cnt qualifies on (out_valid & ~out_ready), evaluated before the edge, including in a flush cycle.
  - flush_cnt qualifies on flush=1 regardless of occupancy.
  - Both counters are cleared only by reset.
- Ordering: payloads leave in acceptance order. No duplication or loss except by flush.
- Reset asserted mid-transfer: all state is cleared, including the counters. Downstream must not rely on an acknowledge in the reset cycle.

Test Plan:
- SKID=1, out_ready=1, in_data=0x0000_0004_2402_0005, then 0x...08_AC41_0000 on consecutive cycles -> each appears on out_data one cycle later, out_valid=1 for 2 cycles, stall_cnt=0.
- SKID=1, out_ready=0, offer payloads A=0x11, B=0x22, C=0x33 on consecutive cycles:
  - A goes to main, B to skid; in_ready=0 from the cycle after B, so C is held upstream.
  - Raise out_ready -> outputs A, B, C in order.
  - stall_cnt equals the number of low-ready cycles with out_valid=1.
- Stage full (main A, skid B) plus flush=1 with in_valid carrying C -> next cycle out_valid=0, out_data=0, in_ready=1, flush_cnt=1. C is never output.
- SKID=0, out_ready toggling 1,0,1 with continuous in_valid:
  - in_ready follows ~main_valid|out_ready combinationally.
  - No payload is lost or duplicated.
- CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Assert reset -> stall_cnt=0, out_valid=0 on the next cycle.
- Assert reset while the skid is full and flush=1 simultaneously -> the reset result matches the reset values exactly. flush_cnt=0, not 1.
